pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 9 +
 rtl/pc_ras.sv | 65 ++++++
 rtl/pc_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator: reset vector, instruction stride
// and word-alignment mask.
package pc_gen_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1bff_fffc;
  localparam logic [31:0] PC_STRIDE        = 32'h0000_0004;
  localparam logic [31:0] ALIGN_MASK       = 32'hffff_fffc;

endpackage : pc_gen_pkg

// File: rtl/pc_ras.sv
// Circular return-address stack: pointer names the next free slot, top is the
// slot just below it, and a push when full silently overwrites the oldest entry.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW + 1)'(DEPTH);

  logic [XLEN-1:0] mem_r [DEPTH];
  logic [PW-1:0]   ptr_r;
  logic [PW:0]     cnt_r;
  logic [PW-1:0]   top_idx_s;

  assign top_idx_s = ptr_r - PW'(1);
  assign top       = mem_r[top_idx_s];
  assign empty     = (cnt_r == {(PW + 1){1'b0}});
  assign full      = (cnt_r == CNT_MAX);

  // Pointer and occupancy count; count saturates so overwrite-on-full keeps full set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= {PW{1'b0}};
      cnt_r <= {(PW + 1){1'b0}};
    end else if (push) begin
      ptr_r <= ptr_r + PW'(1);
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + (PW + 1)'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (pop && !empty) begin
      ptr_r <= top_idx_s;
      cnt_r <= cnt_r - (PW + 1)'(1);
    end else begin
      ptr_r <= ptr_r;
      cnt_r <= cnt_r;
    end
  end

  // Entry storage carries no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[ptr_r] <= wdata;
    end else if (replace) begin
      mem_r[top_idx_s] <= wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

endmodule : pc_ras

// File: rtl/pc_gen.sv
// Fetch PC register with next-PC priority mux: redirect > stall > return >
// call > sequential, plus return-address-stack bookkeeping.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            call_valid,
  input  logic [XLEN-1:0] call_target,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] STRIDE = XLEN'(PC_STRIDE);
  localparam logic [XLEN-1:0] AMASK  = ~(XLEN'(~ALIGN_MASK));

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] npc_s;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_push_s;
  logic            ras_pop_s;
  logic            ras_replace_s;

  assign seq_pc_s = pc_r + STRIDE;

  // Next-PC selection; RAS is only touched on the unstalled, unredirected path.
  always_comb begin
    npc_s         = seq_pc_s;
    ras_push_s    = 1'b0;
    ras_pop_s     = 1'b0;
    ras_replace_s = 1'b0;
    if (redirect_valid) begin
      npc_s = redirect_pc & AMASK;
    end else if (stall) begin
      npc_s = pc_r;
    end else if (ret_valid) begin
      npc_s = ras_empty ? seq_pc_s : ras_top_s;
      if (call_valid) begin
        ras_replace_s = 1'b1;
      end else begin
        ras_pop_s = 1'b1;
      end
    end else if (call_valid) begin
      npc_s      = call_target & AMASK;
      ras_push_s = 1'b1;
    end else begin
      npc_s = seq_pc_s;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= npc_s;
    end
  end

  assign pc  = pc_r;
  assign npc = npc_s;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rstn    (rstn),
    .push    (ras_push_s),
    .pop     (ras_pop_s),
    .replace (ras_replace_s),
    .wdata   (seq_pc_s),
    .top     (ras_top_s),
    .empty   (ras_empty),
    .full    (ras_full)
  );

endmodule : pc_gen
